// File: rtl/alarm_adjust_ctrl.sv
// alarm_adjust_ctrl
// Adjust-mode controller for the alarm clock. Five debounced button pulses
// drive a NORMAL / ADJUST / COMMIT state machine that edits the clock time
// (handed to the timekeeper through a one-cycle load strobe) and the alarm
// time (held here). Every output comes straight from a flop.

module alarm_adjust_ctrl #(
   parameter int HOUR_MAX = 23,
   parameter int MIN_MAX  = 59
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_c,
   input  logic       btn_u,
   input  logic       btn_d,
   input  logic       btn_l,
   input  logic       btn_r,
   input  logic [4:0] cur_hour,
   input  logic [5:0] cur_min,
   output logic       adj_mode,
   output logic [1:0] sel,
   output logic [4:0] set_hour,
   output logic [5:0] set_min,
   output logic       set_load,
   output logic [4:0] alm_hour,
   output logic [5:0] alm_min
);

   localparam logic [4:0] HMAX = 5'(HOUR_MAX);
   localparam logic [5:0] MMAX = 6'(MIN_MAX);

   localparam logic [1:0] SEL_CLK_HOUR = 2'd0;
   localparam logic [1:0] SEL_CLK_MIN  = 2'd1;
   localparam logic [1:0] SEL_ALM_HOUR = 2'd2;
   localparam logic [1:0] SEL_ALM_MIN  = 2'd3;

   typedef enum logic [1:0] {
      NORMAL = 2'd0,
      ADJUST = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] sel_d;
   logic [4:0] set_hour_d, alm_hour_d;
   logic [5:0] set_min_d, alm_min_d;

   // Hour and minute fields wrap independently; anything at or above the
   // maximum is treated as the maximum so a bad snapshot still wraps cleanly.
   function automatic logic [4:0] hour_up(input logic [4:0] v);
      return (v >= HMAX) ? 5'd0 : v + 5'd1;
   endfunction

   function automatic logic [4:0] hour_down(input logic [4:0] v);
      return (v == 5'd0 || v > HMAX) ? HMAX : v - 5'd1;
   endfunction

   function automatic logic [5:0] min_up(input logic [5:0] v);
      return (v >= MMAX) ? 6'd0 : v + 6'd1;
   endfunction

   function automatic logic [5:0] min_down(input logic [5:0] v);
      return (v == 6'd0 || v > MMAX) ? MMAX : v - 6'd1;
   endfunction

   // Next-state and next-register logic; one button action per cycle in ADJUST
   always_comb begin
      state_d    = state_q;
      sel_d      = sel;
      set_hour_d = set_hour;
      set_min_d  = set_min;
      alm_hour_d = alm_hour;
      alm_min_d  = alm_min;

      case (state_q)
         NORMAL: begin
            if (btn_c) begin
               state_d    = ADJUST;
               sel_d      = SEL_CLK_HOUR;
               set_hour_d = cur_hour;
               set_min_d  = cur_min;
            end
         end

         ADJUST: begin
            if (btn_c) begin
               state_d = COMMIT;
            end else if (btn_u) begin
               case (sel)
                  SEL_CLK_HOUR: set_hour_d = hour_up(set_hour);
                  SEL_CLK_MIN:  set_min_d  = min_up(set_min);
                  SEL_ALM_HOUR: alm_hour_d = hour_up(alm_hour);
                  default:      alm_min_d  = min_up(alm_min);
               endcase
            end else if (btn_d) begin
               case (sel)
                  SEL_CLK_HOUR: set_hour_d = hour_down(set_hour);
                  SEL_CLK_MIN:  set_min_d  = min_down(set_min);
                  SEL_ALM_HOUR: alm_hour_d = hour_down(alm_hour);
                  default:      alm_min_d  = min_down(alm_min);
               endcase
            end else if (btn_l) begin
               sel_d = sel - 2'd1;
            end else if (btn_r) begin
               sel_d = sel + 2'd1;
            end
         end

         COMMIT: begin
            state_d = NORMAL;
         end

         default: begin
            state_d = NORMAL;
         end
      endcase
   end

   // State and output registers; the mode flag and load strobe are decoded
   // from the next state so they line up with the state they describe
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= NORMAL;
         adj_mode <= 1'b0;
         set_load <= 1'b0;
         sel      <= SEL_CLK_HOUR;
         set_hour <= 5'd0;
         set_min  <= 6'd0;
         alm_hour <= 5'd0;
         alm_min  <= 6'd0;
      end else begin
         state_q  <= state_d;
         adj_mode <= (state_d == ADJUST);
         set_load <= (state_d == COMMIT);
         sel      <= sel_d;
         set_hour <= set_hour_d;
         set_min  <= set_min_d;
         alm_hour <= alm_hour_d;
         alm_min  <= alm_min_d;
      end
   end

endmodule

// File: tb/tb_alarm_adjust_ctrl.sv
// Testbench for alarm_adjust_ctrl. A behavioural model predicts the outputs
// for each driven cycle; the prediction is queued and compared once the DUT
// has clocked. Asynchronous resets are checked directly against zero.

module tb_alarm_adjust_ctrl;

   localparam int HMAX = 23;
   localparam int MMAX = 59;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       btnC = 1'b0, btnU = 1'b0, btnD = 1'b0, btnL = 1'b0, btnR = 1'b0;
   logic [4:0] curHour = 5'd0;
   logic [5:0] curMin = 6'd0;
   logic       adjMode, setLoad;
   logic [1:0] sel;
   logic [4:0] setHour, almHour;
   logic [5:0] setMin, almMin;

   int testsRun = 0;
   int testsFailed = 0;

   typedef struct {
      int adj; int sel; int sh; int sm; int load; int ah; int am;
   } exp_t;

   exp_t sbQ[$];

   // Model state: 0 normal, 1 adjust, 2 commit
   int mState, mSel, mSh, mSm, mAh, mAm;

   alarm_adjust_ctrl #(.HOUR_MAX(HMAX), .MIN_MAX(MMAX)) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_c    (btnC),
      .btn_u    (btnU),
      .btn_d    (btnD),
      .btn_l    (btnL),
      .btn_r    (btnR),
      .cur_hour (curHour),
      .cur_min  (curMin),
      .adj_mode (adjMode),
      .sel      (sel),
      .set_hour (setHour),
      .set_min  (setMin),
      .set_load (setLoad),
      .alm_hour (almHour),
      .alm_min  (almMin)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int act, input int exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic modelReset();
      mState = 0; mSel = 0; mSh = 0; mSm = 0; mAh = 0; mAm = 0;
   endtask

   function automatic int stepField(input int v, input int maxv, input int delta);
      return (v + delta + maxv + 1) % (maxv + 1);
   endfunction

   task automatic modelStep(input bit c, u, d, l, r, input int ch, input int cm);
      int delta;
      if (mState == 0) begin
         if (c) begin
            mState = 1; mSel = 0; mSh = ch; mSm = cm;
         end
      end else if (mState == 1) begin
         delta = u ? 1 : (d ? -1 : 0);
         if (c) begin
            mState = 2;
         end else if (delta != 0) begin
            if (mSel == 0)      mSh = stepField(mSh, HMAX, delta);
            else if (mSel == 1) mSm = stepField(mSm, MMAX, delta);
            else if (mSel == 2) mAh = stepField(mAh, HMAX, delta);
            else                mAm = stepField(mAm, MMAX, delta);
         end else if (l) begin
            mSel = (mSel + 3) % 4;
         end else if (r) begin
            mSel = (mSel + 1) % 4;
         end
      end else begin
         mState = 0;
      end
   endtask

   task automatic checkCycle(input string tag);
      exp_t e;
      if (sbQ.size() == 0) begin
         checkOutput({tag, "_queue"}, 0, 1);
         return;
      end
      e = sbQ.pop_front();
      checkOutput({tag, "_adj"},  int'(adjMode), e.adj);
      checkOutput({tag, "_sel"},  int'(sel),     e.sel);
      checkOutput({tag, "_sh"},   int'(setHour), e.sh);
      checkOutput({tag, "_sm"},   int'(setMin),  e.sm);
      checkOutput({tag, "_load"}, int'(setLoad), e.load);
      checkOutput({tag, "_ah"},   int'(almHour), e.ah);
      checkOutput({tag, "_am"},   int'(almMin),  e.am);
   endtask

   // Drive one cycle of buttons at the falling edge, predict, then compare
   task automatic applyStimulus(input string tag, input bit c, u, d, l, r,
                                input int ch = 0, input int cm = 0);
      exp_t e;
      @(negedge clk);
      btnC = c; btnU = u; btnD = d; btnL = l; btnR = r;
      curHour = 5'(ch); curMin = 6'(cm);
      modelStep(c, u, d, l, r, ch, cm);
      e.adj = (mState == 1) ? 1 : 0;
      e.sel = mSel; e.sh = mSh; e.sm = mSm;
      e.load = (mState == 2) ? 1 : 0;
      e.ah = mAh; e.am = mAm;
      sbQ.push_back(e);
      @(posedge clk);
      #1;
      btnC = 0; btnU = 0; btnD = 0; btnL = 0; btnR = 0;
      checkCycle(tag);
   endtask

   task automatic checkZero(input string tag);
      checkOutput({tag, "_adj"},  int'(adjMode), 0);
      checkOutput({tag, "_sel"},  int'(sel),     0);
      checkOutput({tag, "_sh"},   int'(setHour), 0);
      checkOutput({tag, "_sm"},   int'(setMin),  0);
      checkOutput({tag, "_load"}, int'(setLoad), 0);
      checkOutput({tag, "_ah"},   int'(almHour), 0);
      checkOutput({tag, "_am"},   int'(almMin),  0);
   endtask

   // Assert reset between clock edges and check it takes effect at once
   task automatic asyncReset(input string tag);
      #2;
      rst = 1'b0;
      #1;
      checkZero(tag);
      @(negedge clk);
      rst = 1'b1;
      modelReset();
   endtask

   // Main sequence
   initial begin
      modelReset();
      #2;
      checkZero("reset");
      @(negedge clk);
      rst = 1'b1;

      // Edit buttons are ignored outside ADJUST
      applyStimulus("normal_u", 0, 1, 0, 0, 0, 13, 45);
      applyStimulus("normal_r", 0, 0, 0, 0, 1, 13, 45);

      // Enter with a 13:45 snapshot, wrap the hour both ways
      applyStimulus("enter", 1, 0, 0, 0, 0, 13, 45);
      for (int i = 0; i < 11; i++) applyStimulus("hour_up", 0, 1, 0, 0, 0, 2, 7);
      applyStimulus("hour_down_wrap", 0, 0, 1, 0, 0);

      // Minute field: bring it to 59, wrap up then back down
      applyStimulus("sel_r", 0, 0, 0, 0, 1);
      for (int i = 0; i < 14; i++) applyStimulus("min_up", 0, 1, 0, 0, 0);
      applyStimulus("min_up_wrap", 0, 1, 0, 0, 0);
      applyStimulus("min_down_wrap", 0, 0, 1, 0, 0);

      // Selection wraps both ways
      applyStimulus("sel_l", 0, 0, 0, 1, 0);
      applyStimulus("sel_l_wrap", 0, 0, 0, 1, 0);
      applyStimulus("sel_r_wrap", 0, 0, 0, 0, 1);

      // Alarm hour 7, alarm minute 59 via down-wrap
      applyStimulus("sel_r", 0, 0, 0, 0, 1);
      applyStimulus("sel_r", 0, 0, 0, 0, 1);
      for (int i = 0; i < 7; i++) applyStimulus("alm_hour_up", 0, 1, 0, 0, 0);
      applyStimulus("sel_r", 0, 0, 0, 0, 1);
      applyStimulus("alm_min_down", 0, 0, 1, 0, 0);

      // Commit; a centre press during COMMIT is dropped
      applyStimulus("commit", 1, 0, 0, 0, 0);
      applyStimulus("commit_drop_c", 1, 0, 0, 0, 0, 9, 9);
      applyStimulus("idle", 0, 0, 0, 0, 0);

      // Re-enter: alarm persists, new snapshot taken
      applyStimulus("reenter", 1, 0, 0, 0, 0, 5, 10);

      // Centre beats up; then back in, up beats right
      applyStimulus("c_and_u", 1, 1, 0, 0, 0);
      applyStimulus("to_normal", 0, 0, 0, 0, 0);
      applyStimulus("reenter2", 1, 0, 0, 0, 0, 22, 0);
      applyStimulus("u_and_r", 0, 1, 0, 0, 1);
      applyStimulus("d_and_l", 0, 0, 1, 1, 0);

      // Asynchronous reset mid-ADJUST with alarm 07:59
      asyncReset("rst_adjust");
      applyStimulus("post_rst_idle", 0, 1, 0, 0, 0, 4, 4);
      applyStimulus("post_rst_enter", 1, 0, 0, 0, 0, 4, 4);

      // Asynchronous reset during COMMIT suppresses the load strobe
      applyStimulus("commit2", 1, 0, 0, 0, 0);
      asyncReset("rst_commit");
      applyStimulus("post_rst2", 0, 0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

endmodule
